// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and default width.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - z, producing difference and borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic f_d,
    output logic f_b
);

    always_comb begin
        f_d = x ^ y ^ z;
        f_b = (~x & y) | (~(x ^ y) & z);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_d, bit_b;
    logic [WIDTH-1:0] shifted;

    full_subtractor u_fs (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .z   (borrow_q),
        .f_d (bit_d),
        .f_b (bit_b)
    );

    // The newest bit enters at the MSB; on the last step this is the full result.
    assign shifted = {bit_d, work_q};

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        work_d       = work_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = bit_b;
                cnt_d    = cnt_q + CNT_W'(1);
                work_d   = shifted[WIDTH-1:1];
                if (cnt_q == LAST) begin
                    diff_d       = shifted;
                    borrow_out_d = bit_b;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                // Unused encodings fall back to idle behaviour.
                state_d = ST_IDLE;
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            work_q       <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            work_q       <= work_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed + random) and WIDTH=3 (exhaustive).
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, busy8, done8, bor8;
    logic [7:0] a8, b8, diff8;
    logic       start3, busy3, done3, bor3;
    logic [2:0] a3, b3, diff3;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bor3)
    );

    typedef struct packed { logic [7:0] d; logic b; } exp8_t;
    typedef struct packed { logic [2:0] d; logic b; } exp3_t;

    exp8_t sb8[$];
    exp3_t sb3[$];
    exp8_t cur8, last8, mon8_e;
    exp3_t cur3, mon3_e;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer subtraction reduced modulo 2^W, borrow = unsigned a < b.
    function automatic exp8_t model8(input int a, input int b);
        exp8_t e;
        e.d = 8'((a - b) & 255);
        e.b = (a < b);
        return e;
    endfunction

    function automatic exp3_t model3(input int a, input int b);
        exp3_t e;
        e.d = 3'((a - b) & 7);
        e.b = (a < b);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (sb8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                mon8_e = sb8.pop_front();
                check("diff8", {24'd0, diff8}, {24'd0, mon8_e.d});
                check("borrow8", {31'd0, bor8}, {31'd0, mon8_e.b});
            end
        end
    end

    always @(negedge clk) begin
        if (done3 === 1'b1) begin
            if (sb3.size() == 0) check("unexpected_done3", 1, 0);
            else begin
                mon3_e = sb3.pop_front();
                check("diff3", {29'd0, diff3}, {29'd0, mon3_e.d});
                check("borrow3", {31'd0, bor3}, {31'd0, mon3_e.b});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input int a, input int b, input bit push);
        start8 = 1'b1;
        a8 = 8'(a);
        b8 = 8'(b);
        if (push) begin
            cur8 = model8(a, b);
            sb8.push_back(cur8);
        end
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        check("busy_after_start8", {31'd0, busy8}, 1);
        check("done_low_after_start8", {31'd0, done8}, 0);
    endtask

    // noise: -1 quiet, -2 random start pulses while busy, >=0 one start pulse (a=b=1) at that cycle.
    task automatic wait8(input int noise);
        int n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            check("hold_diff8", {24'd0, diff8}, {24'd0, last8.d});
            check("hold_borrow8", {31'd0, bor8}, {31'd0, last8.b});
            check("busy8", {31'd0, busy8}, 1);
            if (noise == -2) begin
                start8 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else if (noise == n) begin
                start8 = 1'b1;
                a8 = 8'd1;
                b8 = 8'd1;
            end else begin
                start8 = 1'b0;
            end
            tick();
            n++;
        end
        start8 = 1'b0;
        check("latency8", n, 8);
        check("busy_low_in_done8", {31'd0, busy8}, 0);
        last8 = cur8;
    endtask

    initial begin
        int gap;
        int n;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0;
        last8 = '0;
        cur8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy8", {31'd0, busy8}, 0);
        check("rst_done8", {31'd0, done8}, 0);
        check("rst_diff8", {24'd0, diff8}, 0);
        check("rst_borrow8", {31'd0, bor8}, 0);
        check("rst_busy3", {31'd0, busy3}, 0);
        check("rst_diff3", {29'd0, diff3}, 0);
        rst = 1'b0;
        tick();

        issue8(100, 37, 1'b1); wait8(-1); tick();
        check("done_pulse_once8", {31'd0, done8}, 0);

        issue8(5, 9, 1'b1);    wait8(-1); tick();
        issue8(0, 1, 1'b1);    wait8(-1); tick();
        issue8(255, 0, 1'b1);  wait8(-1); tick();

        issue8(50, 20, 1'b1);  wait8(2);  tick();
        check("ignored_start_no_done", {31'd0, done8}, 0);
        check("ignored_start_idle", {31'd0, busy8}, 0);

        issue8(10, 3, 1'b1);   wait8(-1);
        issue8(3, 10, 1'b1);   wait8(-1); tick();

        // Abort mid-operation.
        issue8(200, 1, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy8", {31'd0, busy8}, 0);
        check("abort_done8", {31'd0, done8}, 0);
        check("abort_diff8", {24'd0, diff8}, 0);
        check("abort_borrow8", {31'd0, bor8}, 0);
        last8 = '0;
        cur8 = '0;
        repeat (12) begin
            check("no_done_after_abort", {31'd0, done8}, 0);
            tick();
        end
        issue8(9, 4, 1'b1);    wait8(-1); tick();

        repeat (40) begin
            issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
            wait8(-2);
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
        end
        tick();

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                start3 = 1'b1;
                a3 = 3'(a);
                b3 = 3'(b);
                cur3 = model3(a, b);
                sb3.push_back(cur3);
                tick();
                start3 = 1'b0;
                a3 = 3'($urandom);
                b3 = 3'($urandom);
                n = 0;
                while (done3 !== 1'b1 && n < 20) begin
                    check("busy3", {31'd0, busy3}, 1);
                    tick();
                    n++;
                end
                check("latency3", n, 3);
                tick();
                check("done_pulse_once3", {31'd0, done3}, 0);
            end
        end

        repeat (2) tick();
        check("sb8_drained", sb8.size(), 0);
        check("sb3_drained", sb3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
